// File: rtl/mem_access_wb_reg_if.sv
// mem_access_wb_reg_if: data-memory request/response bus between the MEM stage and data memory
interface mem_access_wb_reg_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_wb_reg.sv
// mem_access_wb_reg: MEM-stage data-memory handshake with pipeline stall, timeout abort and MEM/WB register
module mem_access_wb_reg #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWriteM,
  input  logic                MemWriteM,
  input  logic [1:0]          ResultSrcM,
  input  logic [31:0]         ALUResultM,
  input  logic [31:0]         WriteDataM,
  input  logic [31:0]         PCPlus4M,
  input  logic [4:0]          RdM,
  mem_access_wb_reg_if.master dmem,
  output logic                StallM,
  output logic                RegWriteW,
  output logic [1:0]          ResultSrcW,
  output logic [31:0]         ALUResultW,
  output logic [31:0]         ReadDataW,
  output logic [31:0]         PCPlus4W,
  output logic [4:0]          RdW,
  output logic                MemErr
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        access, load, hs, timeout;
  logic        reg_write_w_q, reg_write_w_d;
  logic [1:0]  result_src_w_q, result_src_w_d;
  logic [31:0] alu_result_w_q, alu_result_w_d;
  logic [31:0] read_data_w_q, read_data_w_d;
  logic [31:0] pc_plus4_w_q, pc_plus4_w_d;
  logic [4:0]  rd_w_q, rd_w_d;
  logic        mem_err_q, mem_err_d;
  // hs is the handshake the current wait state is waiting for; it beats a coincident timeout
  always_comb begin
    access           = MemWriteM | (ResultSrcM == 2'b01);
    load             = access & ~MemWriteM;
    hs               = (state_q == WAIT_ACK) ? dmem.dmem_ready : (state_q == WAIT_DATA) & dmem.dmem_rvalid;
    timeout          = (state_q != IDLE) & ~hs & (cnt_q >= TMO);
    dmem.dmem_req    = (state_q == IDLE) ? access : (state_q == WAIT_ACK) & ~timeout;
    dmem.dmem_we     = MemWriteM;
    dmem.dmem_addr   = ALUResultM;
    dmem.dmem_wdata  = WriteDataM;
    StallM           = (state_q == IDLE) ? access & ~(MemWriteM & dmem.dmem_ready)
                     : ~timeout & ~(hs & ((state_q == WAIT_DATA) | MemWriteM));
    state_d          = (state_q == IDLE) ? (!access ? IDLE : !dmem.dmem_ready ? WAIT_ACK : load ? WAIT_DATA : IDLE)
                     : (timeout || (hs && (state_q == WAIT_DATA || MemWriteM))) ? IDLE
                     : hs ? WAIT_DATA : state_q;
    cnt_d            = (state_q == IDLE) ? 16'd0 : cnt_q + 16'd1;
    reg_write_w_d    = ~StallM & ~timeout & RegWriteM;
    result_src_w_d   = StallM ? result_src_w_q : ResultSrcM;
    alu_result_w_d   = StallM ? alu_result_w_q : ALUResultM;
    pc_plus4_w_d     = StallM ? pc_plus4_w_q : PCPlus4M;
    rd_w_d           = StallM ? rd_w_q : RdM;
    read_data_w_d    = (state_q == WAIT_DATA && dmem.dmem_rvalid) ? dmem.dmem_rdata : read_data_w_q;
    mem_err_d        = mem_err_q | timeout;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= '0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
      pc_plus4_w_q   <= '0;
      rd_w_q         <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
      pc_plus4_w_q   <= pc_plus4_w_d;
      rd_w_q         <= rd_w_d;
      mem_err_q      <= mem_err_d;
    end
  end
  assign RegWriteW  = reg_write_w_q;
  assign ResultSrcW = result_src_w_q;
  assign ALUResultW = alu_result_w_q;
  assign ReadDataW  = read_data_w_q;
  assign PCPlus4W   = pc_plus4_w_q;
  assign RdW        = rd_w_q;
  assign MemErr     = mem_err_q;
endmodule

// File: tb/tb_mem_access_wb_reg.sv
// tb_mem_access_wb_reg: randomized transaction bench with a per-transaction latency model of the MEM stage
module tb_mem_access_wb_reg;
  localparam int TMO = 4;
  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [4:0]  rd;
  } wb_t;
  logic clk = 1'b0;
  logic reset;
  logic RegWriteM, MemWriteM;
  logic [1:0] ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0] RdM;
  logic StallM, RegWriteW, MemErr;
  logic [1:0] ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0] RdW;
  wb_t exp, act;
  logic exp_err;
  int checks = 0, errors = 0;
  mem_access_wb_reg_if dmem_if();
  mem_access_wb_reg #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .dmem(dmem_if),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW), .MemErr(MemErr)
  );
  always #5 clk = ~clk;
  assign act = {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW};
  // One M-stage instruction: ready arrives r cycles after the IDLE cycle, read data d cycles after ready.
  // The instruction finishes at cycle r (store) or r+d (load) unless that exceeds TMO+1, where it aborts.
  task automatic run_txn(input logic rw, input logic mw, input logic [1:0] rs, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc, input logic [4:0] rd,
                         input int r, input int d, input logic [31:0] rdat);
    logic acc, ld, abort, exp_req;
    int cend;
    acc = mw | (rs == 2'b01);
    ld = acc & ~mw;
    cend = !acc ? 0 : ld ? r + d : r;
    abort = cend > TMO + 1;
    if (abort) cend = TMO + 1;
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; ALUResultM = alu;
    WriteDataM = wd; PCPlus4M = pc; RdM = rd;
    for (int k = 0; k <= cend; k++) begin
      dmem_if.dmem_ready  = acc ? (k == r) || (k > r && $urandom_range(1) != 0) : $urandom_range(1) != 0;
      dmem_if.dmem_rvalid = (ld && k == r + d) || ((!ld || k <= r) && $urandom_range(1) != 0);
      dmem_if.dmem_rdata  = (ld && k == r + d) ? rdat : $urandom;
      @(negedge clk);
      checks++;
      if (StallM !== (k < cend)) begin
        errors++; $display("FAIL stall k=%0d got %b exp %b", k, StallM, k < cend);
      end
      exp_req = acc && ((k < r && k < TMO + 1) || k == r);
      checks++;
      if (dmem_if.dmem_req !== exp_req) begin
        errors++; $display("FAIL dmem_req k=%0d got %b exp %b", k, dmem_if.dmem_req, exp_req);
      end
      if (exp_req) begin
        checks++;
        if ({dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_wdata} !== {mw, alu, wd}) begin
          errors++; $display("FAIL dmem_bus got %b %h %h exp %b %h %h", dmem_if.dmem_we,
                             dmem_if.dmem_addr, dmem_if.dmem_wdata, mw, alu, wd);
        end
      end
      @(posedge clk);
      if (k < cend) exp.rw = 1'b0;
      else begin
        exp = '{rw & ~abort, rs, alu, (ld && !abort) ? rdat : exp.rdata, pc, rd};
        exp_err = exp_err | abort;
      end
      #1;
      checks++;
      if (act !== exp) begin
        errors++; $display("FAIL wb_regs k=%0d got %h exp %h", k, act, exp);
      end
      checks++;
      if (MemErr !== exp_err) begin
        errors++; $display("FAIL mem_err k=%0d got %b exp %b", k, MemErr, exp_err);
      end
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    {RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM} = '0;
    dmem_if.dmem_ready = 1'b0; dmem_if.dmem_rvalid = 1'b0; dmem_if.dmem_rdata = '0;
    exp = '0; exp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL reset_wb got %h exp %h", act, exp); end
    checks++;
    if (MemErr !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", MemErr); end
    checks++;
    if ({StallM, dmem_if.dmem_req} !== 2'b00) begin
      errors++; $display("FAIL reset_stall_req got %b%b exp 00", StallM, dmem_if.dmem_req);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask
  task automatic test_alu_op;
    run_txn(1'b1, 1'b0, 2'b00, 32'h10, $urandom, $urandom, 5'd5, 0, 1, 32'h0);
  endtask
  task automatic test_store;
    run_txn(1'b0, 1'b1, 2'b00, 32'h100, 32'hCAFEF00D, $urandom, 5'd0, 0, 1, 32'h0);
  endtask
  task automatic test_load_latency;
    run_txn(1'b1, 1'b0, 2'b01, 32'h200, $urandom, $urandom, 5'd7, 2, 3, 32'h12345678);
  endtask
  task automatic test_timeout;
    run_txn(1'b1, 1'b0, 2'b01, 32'h300, $urandom, $urandom, 5'd3, 0, 100, 32'h0);
    for (int i = 0; i < 3; i++) run_txn(1'b1, 1'b0, 2'b10, $urandom, $urandom, $urandom, 5'd4, 0, 1, 32'h0);
    run_txn(1'b1, 1'b1, 2'b00, 32'h304, $urandom, $urandom, 5'd6, 100, 1, 32'h0);
  endtask
  task automatic test_back_to_back;
    run_txn(1'b0, 1'b1, 2'b00, 32'h400, 32'h11111111, $urandom, 5'd0, 0, 1, 32'h0);
    run_txn(1'b0, 1'b1, 2'b00, 32'h404, 32'h22222222, $urandom, 5'd0, 0, 1, 32'h0);
  endtask
  task automatic test_random(input int n);
    for (int i = 0; i < n; i++)
      run_txn(1'($urandom_range(1)), 1'($urandom_range(3) == 0), 2'($urandom_range(3)), $urandom, $urandom,
              $urandom, 5'($urandom_range(31)), int'($urandom_range(6)), int'($urandom_range(3, 1)), $urandom);
  endtask
  task automatic test_reset_mid;
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; ALUResultM = 32'h40; RdM = 5'd9;
    dmem_if.dmem_ready = 1'b1; dmem_if.dmem_rvalid = 1'b0;
    @(posedge clk); #1;
    dmem_if.dmem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (StallM !== 1'b1) begin errors++; $display("FAIL mid_stall got %b exp 1", StallM); end
    #1 reset = 1'b1;
    {RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM} = '0;
    exp = '0; exp_err = 1'b0;
    #1;
    checks++;
    if (act !== exp) begin errors++; $display("FAIL async_reset_wb got %h exp %h", act, exp); end
    checks++;
    if ({StallM, MemErr} !== 2'b00) begin
      errors++; $display("FAIL async_reset_stall_err got %b%b exp 00", StallM, MemErr);
    end
    dmem_if.dmem_rvalid = 1'b1; dmem_if.dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    checks++;
    if (ReadDataW !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", ReadDataW); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({StallM, dmem_if.dmem_req} !== 2'b00) begin
      errors++; $display("FAIL late_rvalid_stall_req got %b%b exp 00", StallM, dmem_if.dmem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (act !== exp) begin errors++; $display("FAIL late_rvalid_wb got %h exp %h", act, exp); end
    checks++;
    if (MemErr !== 1'b0) begin errors++; $display("FAIL late_rvalid_err got %b exp 0", MemErr); end
    dmem_if.dmem_rvalid = 1'b0;
  endtask
  initial begin
    test_reset;
    test_alu_op;
    test_store;
    test_load_latency;
    test_timeout;
    test_back_to_back;
    test_random(60);
    test_reset_mid;
    test_random(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_wb_reg.md
MEM_ACCESS_WB_REG -- requirements
Module: mem_access_wb_reg

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max cycles waited in WAIT_ACK or WAIT_DATA before abort (1..65535).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: RegWriteM in 1, MemWriteM in 1, ResultSrcM in 2  MEM-stage controls from EX/MEM register.
REQ-005 SHALL have ports: ALUResultM in 32, WriteDataM in 32, PCPlus4M in 32, RdM in 5  MEM-stage data.
REQ-006 SHALL have ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32  data-memory request.
REQ-007 SHALL have ports: dmem_ready in 1 (request accepted), dmem_rvalid in 1 (read data valid), dmem_rdata in 32.
REQ-008 SHALL have port: StallM  out  1  freezes IF/ID/EX/MEM registers while high.
REQ-009 SHALL have ports: RegWriteW out 1, ResultSrcW out 2, ALUResultW out 32, ReadDataW out 32, PCPlus4W out 32, RdW out 5  MEM/WB register.
REQ-010 SHALL have port: MemErr  out  1  sticky timeout flag.

Function
REQ-011 SHALL define access = MemWriteM | (ResultSrcM == 2'b01); store = MemWriteM; load = access & ~MemWriteM.
REQ-012 SHALL implement FSM states IDLE, WAIT_ACK, WAIT_DATA.
REQ-013 SHALL drive dmem_req = 1 combinationally in IDLE with access and throughout WAIT_ACK; 0 otherwise.
REQ-014 SHALL drive dmem_we = MemWriteM, dmem_addr = ALUResultM, dmem_wdata = WriteDataM, unmodified, whenever dmem_req = 1.
REQ-015 IDLE, no access: StallM = 0; W registers load M values next edge; ReadDataW holds.
REQ-016 IDLE, access, dmem_ready = 1: store completes same cycle (StallM = 0, W loads); load -> WAIT_DATA, StallM = 1.
REQ-017 IDLE, access, dmem_ready = 0: -> WAIT_ACK, StallM = 1.
REQ-018 WAIT_ACK: StallM = 1 until dmem_ready; on ready, store -> IDLE with StallM = 0 that cycle and W load; load -> WAIT_DATA with StallM = 1.
REQ-019 WAIT_DATA: StallM = 1 until dmem_rvalid; on rvalid, StallM = 0, ReadDataW <= dmem_rdata, W loads M values, -> IDLE.
REQ-020 dmem_rvalid outside WAIT_DATA SHALL be ignored; dmem_ready outside a driven request SHALL be ignored.
REQ-021 Every cycle with StallM = 1 SHALL load RegWriteW <= 0 (bubble); other W fields hold.
REQ-022 SHALL count cycles spent in WAIT_ACK/WAIT_DATA with a counter cleared on entering either state from IDLE.
REQ-023 When counter reaches TIMEOUT_CYCLES without the awaited handshake: dmem_req = 0, StallM = 0, -> IDLE, W loads M values but RegWriteW <= 0, MemErr <= 1.
REQ-024 MemErr SHALL remain 1 until reset.
REQ-025 M inputs SHALL be treated as stable while StallM = 1 (upstream frozen); no internal copy required.
REQ-026 Back-to-back accesses SHALL take a fresh IDLE decision each cycle; no idle cycle inserted between completions.

Reset
REQ-027 On reset assertion, state SHALL become IDLE and counter 0 immediately, irrespective of clk.
REQ-028 During reset all W outputs SHALL be 0, MemErr = 0; dmem_req and StallM follow REQ-013/015/016/017 with state IDLE.
REQ-029 Reset mid-transaction SHALL abandon the access without completion; a late dmem_rvalid SHALL be ignored.

Verification
REQ-030 ALU op: RegWriteM=1, ResultSrcM=00, ALUResultM=0x10, RdM=5 -> next edge RegWriteW=1, ALUResultW=0x10, RdW=5; dmem_req=0, StallM=0.
REQ-031 Store, ready=1 same cycle: MemWriteM=1, ALUResultM=0x100, WriteDataM=0xCAFEF00D -> dmem_req=1, dmem_we=1, dmem_addr=0x100, StallM=0, no stall cycles.
REQ-032 Load, ready after 2 cycles, rvalid 3 cycles later with 0x12345678, RdM=7 -> StallM=1 for 5 cycles, RegWriteW=0 during stall, then RegWriteW=1, ReadDataW=0x12345678, RdW=7.
REQ-033 Load with TIMEOUT_CYCLES=4, rvalid never -> StallM drops after 4 WAIT_DATA cycles, RegWriteW=0, MemErr=1 and stays 1.
REQ-034 Reset asserted in WAIT_DATA, then rvalid=1 with 0xFFFFFFFF -> state IDLE, ReadDataW=0, RegWriteW=0, MemErr=0, StallM=0 after reset.
REQ-035 Two consecutive stores, each ready=1 -> two requests on adjacent cycles, StallM never asserted.
